// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: left-to-right square-and-multiply
// in the Montgomery domain, driving an external MonPro unit.
module mod_exp_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int EXP_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] base,
    input  logic [EXP_WIDTH-1:0]  exponent,
    input  logic [WORD_WIDTH-1:0] modulus,
    input  logic [WORD_WIDTH-1:0] r2_mod_m,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  mm_enable,
    output logic [WORD_WIDTH-1:0] mm_x,
    output logic [WORD_WIDTH-1:0] mm_y,
    output logic [WORD_WIDTH-1:0] mm_m,
    input  logic                  mm_done,
    input  logic [WORD_WIDTH-1:0] mm_result
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_XBAR = 3'd0;
    localparam logic [2:0] OP_ABAR = 3'd1;
    localparam logic [2:0] OP_SQR  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_OUT  = 3'd4;

    localparam logic [WORD_WIDTH-1:0] ONE     = WORD_WIDTH'(1);
    localparam logic [IW-1:0]         IDX_TOP = IW'(EXP_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [WORD_WIDTH-1:0] xbar_q, xbar_d;
    logic [WORD_WIDTH-1:0] base_q, base_d;
    logic [WORD_WIDTH-1:0] r2_q, r2_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic [WORD_WIDTH-1:0] mm_x_q, mm_x_d;
    logic [WORD_WIDTH-1:0] mm_y_q, mm_y_d;
    logic [WORD_WIDTH-1:0] mm_m_q, mm_m_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic                  mm_enable_q, mm_enable_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  issue;
    logic [2:0]            nxt_op;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        xbar_d      = xbar_q;
        base_d      = base_q;
        r2_d        = r2_q;
        exp_d       = exp_q;
        mm_x_d      = mm_x_q;
        mm_y_d      = mm_y_q;
        mm_m_d      = mm_m_q;
        result_d    = result_q;
        busy_d      = busy_q;
        mm_enable_d = 1'b0;
        done_d      = 1'b0;
        issue       = 1'b0;
        nxt_op      = op_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exponent;
                    r2_d    = r2_mod_m;
                    mm_m_d  = modulus;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                    issue   = 1'b1;
                    nxt_op  = OP_XBAR;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mm_done) begin
                    state_d = S_ISSUE;
                    issue   = 1'b1;
                    case (op_q)
                        OP_XBAR: begin
                            xbar_d = mm_result;
                            nxt_op = OP_ABAR;
                        end
                        OP_ABAR: begin
                            acc_d  = mm_result;
                            nxt_op = OP_SQR;
                        end
                        OP_SQR: begin
                            acc_d = mm_result;
                            if (exp_q[idx_q]) begin
                                nxt_op = OP_MUL;
                            end else if (idx_q == '0) begin
                                nxt_op = OP_OUT;
                            end else begin
                                idx_d  = idx_q - 1'b1;
                                nxt_op = OP_SQR;
                            end
                        end
                        OP_MUL: begin
                            acc_d = mm_result;
                            if (idx_q == '0) begin
                                nxt_op = OP_OUT;
                            end else begin
                                idx_d  = idx_q - 1'b1;
                                nxt_op = OP_SQR;
                            end
                        end
                        default: begin
                            result_d = mm_result;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = S_DONE;
                            issue    = 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Operands are loaded on the edge entering ISSUE and then held through WAIT
        if (issue) begin
            mm_enable_d = 1'b1;
            op_d        = nxt_op;
            case (nxt_op)
                OP_XBAR: begin
                    mm_x_d = base_d;
                    mm_y_d = r2_d;
                end
                OP_ABAR: begin
                    mm_x_d = ONE;
                    mm_y_d = r2_d;
                end
                OP_SQR: begin
                    mm_x_d = acc_d;
                    mm_y_d = acc_d;
                end
                OP_MUL: begin
                    mm_x_d = acc_d;
                    mm_y_d = xbar_d;
                end
                default: begin
                    mm_x_d = acc_d;
                    mm_y_d = ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_XBAR;
            idx_q       <= IDX_TOP;
            acc_q       <= '0;
            xbar_q      <= '0;
            base_q      <= '0;
            r2_q        <= '0;
            exp_q       <= '0;
            mm_x_q      <= '0;
            mm_y_q      <= '0;
            mm_m_q      <= '0;
            result_q    <= '0;
            mm_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            xbar_q      <= xbar_d;
            base_q      <= base_d;
            r2_q        <= r2_d;
            exp_q       <= exp_d;
            mm_x_q      <= mm_x_d;
            mm_y_q      <= mm_y_d;
            mm_m_q      <= mm_m_d;
            result_q    <= result_d;
            mm_enable_q <= mm_enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign mm_enable = mm_enable_q;
    assign mm_x      = mm_x_q;
    assign mm_y      = mm_y_q;
    assign mm_m      = mm_m_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with a behavioural Montgomery multiplier of
// variable latency and a plain repeated-multiply reference.
module tb_mod_exp_ctrl;

    localparam int W = 8;
    localparam int E = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] base = '0;
    logic [E-1:0] exponent = '0;
    logic [W-1:0] modulus = '0;
    logic [W-1:0] r2_mod_m = '0;
    logic         busy, done, mm_enable;
    logic [W-1:0] result, mm_x, mm_y, mm_m;
    logic         mm_done;
    logic [W-1:0] mm_result;

    int checks = 0;
    int errors = 0;
    int lat_cfg = 2;
    int enable_cnt = 0;
    int done_cnt = 0;
    int unstable = 0;

    mod_exp_ctrl #(.WORD_WIDTH(W), .EXP_WIDTH(E)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base(base),
        .exponent(exponent), .modulus(modulus), .r2_mod_m(r2_mod_m),
        .busy(busy), .done(done), .result(result),
        .mm_enable(mm_enable), .mm_x(mm_x), .mm_y(mm_y), .mm_m(mm_m),
        .mm_done(mm_done), .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] monpro(input int x, input int y, input int m);
        int t;
        t = x * y;
        for (int i = 0; i < W; i++) begin
            if (t % 2 == 1) t = t + m;
            t = t / 2;
        end
        if (t >= m) t = t - m;
        return W'(t);
    endfunction

    function automatic int pow_ref(input int b, input int e, input int m);
        int r;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    // Montgomery multiplier model, reset by the same net as the DUT
    logic         pend;
    int           cnt;
    logic [W-1:0] px, py, pm;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            cnt       <= 0;
            mm_done   <= 1'b0;
            mm_result <= '0;
        end else begin
            mm_done <= 1'b0;
            if (mm_enable) begin
                pend <= 1'b1;
                px   <= mm_x;
                py   <= mm_y;
                pm   <= mm_m;
                cnt  <= lat_cfg - 1;
            end else if (pend) begin
                if (cnt <= 1) begin
                    mm_done   <= 1'b1;
                    mm_result <= monpro(int'(px), int'(py), int'(pm));
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mm_enable) enable_cnt <= enable_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (pend && (mm_x !== px || mm_y !== py || mm_m !== pm))
            unstable <= unstable + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input int b, input int e, input int m,
                       input int repulse);
        int en0, dn0, us0, cycles, gaps;
        en0 = enable_cnt;
        dn0 = done_cnt;
        us0 = unstable;
        @(negedge clk);
        start    = 1'b1;
        base     = W'(b);
        exponent = E'(e);
        modulus  = W'(m);
        r2_mod_m = W'((1 << (2 * W)) % m);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
        cycles = 0;
        gaps = 0;
        while (!done && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (cycles == repulse) begin
                start    = 1'b1;
                base     = 8'd9;
                exponent = 8'd3;
                modulus  = 8'd11;
                r2_mod_m = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (!done && !busy) gaps++;
        end
        start = 1'b0;
        chk({tag, ".timeout"}, 32'(cycles < 4000), 32'd1);
        chk({tag, ".result"}, 32'(result), 32'(pow_ref(b, e, m)));
        chk({tag, ".busy_gap"}, 32'(gaps), 32'd0);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".monpro_cnt"}, 32'(enable_cnt - en0), 32'(3 + E + $countones(E'(e))));
        chk({tag, ".stable"}, 32'(unstable - us0), 32'd0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done_cnt - dn0), 32'd1);
        chk({tag, ".done_low"}, 32'(done), 32'd0);
        chk({tag, ".result_hold"}, 32'(result), 32'(pow_ref(b, e, m)));
    endtask

    initial begin
        int m, b, e, en0, guard;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.mm_enable", 32'(mm_enable), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.mm_x", 32'(mm_x), 32'd0);
        chk("rst.mm_y", 32'(mm_y), 32'd0);
        chk("rst.mm_m", 32'(mm_m), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        lat_cfg = 2;
        run("d13_4_13", 4, 13, 13, 0);
        chk("d13_4_13.expect4", 32'(result), 32'd4);
        lat_cfg = 3;
        run("d11_7_5", 7, 5, 11, 0);
        chk("d11_7_5.expect10", 32'(result), 32'd10);
        lat_cfg = 4;
        run("d13_5_0", 5, 0, 13, 0);
        chk("d13_5_0.expect1", 32'(result), 32'd1);
        lat_cfg = 2;
        run("d13_0_200", 0, 200, 13, 0);
        lat_cfg = 3;
        run("repulse", 4, 13, 13, 20);
        chk("repulse.expect4", 32'(result), 32'd4);

        // Abort during the fifth WAIT
        lat_cfg = 5;
        en0 = enable_cnt;
        @(negedge clk);
        start = 1'b1; base = 8'd4; exponent = 8'd13;
        modulus = 8'd13; r2_mod_m = 8'd3;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (enable_cnt < en0 + 5 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("abort.reach5", 32'(guard < 2000), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.mm_enable", 32'(mm_enable), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        lat_cfg = 2;
        run("after_abort", 7, 5, 11, 0);

        for (int i = 0; i < 12; i++) begin
            m = 2 * $urandom_range(1, 127) + 1;
            b = $urandom_range(0, m - 1);
            e = $urandom_range(0, 255);
            lat_cfg = $urandom_range(2, 5);
            run($sformatf("rnd%0d", i), b, e, m, (i % 3 == 0) ? 15 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
